// File: rtl/fetch_buffer_mw_pkg.sv
// rtl/fetch_buffer_mw_pkg.sv - shared defaults and entry type for the multi-wide fetch buffer
package fetch_buffer_mw_pkg;

    localparam int FETCH_ADDR_W    = 32;
    localparam int FETCH_INST_W    = 32;
    localparam int FETCH_PC_STEP   = 4;
    localparam int FETCH_BUF_DEPTH = 8;
    localparam int FETCH_IN_WIDTH  = 2;
    localparam int FETCH_OUT_WIDTH = 2;

    // One buffered instruction; pc occupies the upper bits when packed.
    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_INST_W-1:0] inst;
    } fetch_buf_entry_t;

endpackage

// File: rtl/fetch_buffer_mw_if.sv
// rtl/fetch_buffer_mw_if.sv - fetch-group / decode-slot bundle for the fetch buffer
// master: fetch+decode side (drives in_*, dec_stall, flush_; sees in_stall, out_*, count)
// slave : the buffer itself
interface fetch_buffer_mw_if #(
    parameter int ADDR      = 32,
    parameter int INST      = 32,
    parameter int DEPTH     = 8,
    parameter int IN_WIDTH  = 2,
    parameter int OUT_WIDTH = 2
);
    logic                             in_e_;
    logic [$clog2(IN_WIDTH+1)-1:0]    in_cnt;
    logic [ADDR-1:0]                  in_pc;
    logic [IN_WIDTH*INST-1:0]         in_inst;
    logic                             in_stall;
    logic [OUT_WIDTH-1:0]             out_e_;
    logic [OUT_WIDTH*ADDR-1:0]        out_pc;
    logic [OUT_WIDTH*INST-1:0]        out_inst;
    logic                             dec_stall;
    logic                             flush_;
    logic [$clog2(DEPTH+1)-1:0]       count;

    modport master (
        output in_e_, in_cnt, in_pc, in_inst, dec_stall, flush_,
        input  in_stall, out_e_, out_pc, out_inst, count
    );

    modport slave (
        input  in_e_, in_cnt, in_pc, in_inst, dec_stall, flush_,
        output in_stall, out_e_, out_pc, out_inst, count
    );
endinterface

// File: rtl/fetch_buffer_mw_ram.sv
// rtl/fetch_buffer_mw_ram.sv - DEPTH-entry register array, WR_PORTS writes, RD_PORTS async reads
// Ports: clk; we/waddr/wdata per write port; raddr/rdata per read port. Storage is not reset.
module fetch_buffer_mw_ram #(
    parameter int DEPTH    = 8,
    parameter int WIDTH    = 64,
    parameter int WR_PORTS = 2,
    parameter int RD_PORTS = 2,
    localparam int PTR_W   = $clog2(DEPTH)
) (
    input  logic                                clk,
    input  logic [WR_PORTS-1:0]                 we,
    input  logic [WR_PORTS-1:0][PTR_W-1:0]      waddr,
    input  logic [WR_PORTS-1:0][WIDTH-1:0]      wdata,
    input  logic [RD_PORTS-1:0][PTR_W-1:0]      raddr,
    output logic [RD_PORTS-1:0][WIDTH-1:0]      rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Write addresses within one group are always distinct, so port order is irrelevant.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WR_PORTS; i++) begin
            if (we[i]) mem[waddr[i]] <= wdata[i];
        end
    end

    for (genvar j = 0; j < RD_PORTS; j++) begin : g_rd
        assign rdata[j] = mem[raddr[j]];
    end
endmodule

// File: rtl/fetch_buffer_mw.sv
// rtl/fetch_buffer_mw.sv - multi-wide instruction queue between I-cache fetch and decode
// Ports: clk, reset (async, active-high); bus (fetch_buffer_mw_if.slave): fetch group in,
//        OUT_WIDTH decode slots out, dec_stall, flush_, count.
// Optional: FETCH_BUF_BYPASS_EN presents an incoming group directly while the queue is empty.
module fetch_buffer_mw
    import fetch_buffer_mw_pkg::*;
#(
    parameter int ADDR      = FETCH_ADDR_W,
    parameter int INST      = FETCH_INST_W,
    parameter int DEPTH     = FETCH_BUF_DEPTH,
    parameter int IN_WIDTH  = FETCH_IN_WIDTH,
    parameter int OUT_WIDTH = FETCH_OUT_WIDTH,
    parameter int PC_STEP   = FETCH_PC_STEP
) (
    input  logic               clk,
    input  logic               reset,
    fetch_buffer_mw_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int ICW   = $clog2(IN_WIDTH+1);
    localparam int EW    = ADDR + INST;

    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] in_n, skip_n, push_n, pop_n, byp_n;
    logic             push_ok, byp_live;

    logic [IN_WIDTH-1:0]                  we;
    logic [IN_WIDTH-1:0][PTR_W-1:0]       waddr;
    logic [IN_WIDTH-1:0][EW-1:0]          wdata;
    logic [OUT_WIDTH-1:0][PTR_W-1:0]      raddr;
    logic [OUT_WIDTH-1:0][EW-1:0]         rdata;
    logic [OUT_WIDTH-1:0]                 out_e_v;
    logic [OUT_WIDTH-1:0][ADDR-1:0]       out_pc_v;
    logic [OUT_WIDTH-1:0][INST-1:0]       out_inst_v;

    // Out-of-range counts are clamped so a bad in_cnt cannot overrun the write ports.
    assign in_n = (bus.in_cnt > ICW'(IN_WIDTH)) ? CNT_W'(IN_WIDTH) : CNT_W'(bus.in_cnt);

    // Registered count only: a pop in this cycle does not free space for this cycle's push.
    assign bus.in_stall = count_q > CNT_W'(DEPTH - IN_WIDTH);
    assign bus.count    = count_q;

    assign push_ok = !bus.in_e_ && !bus.in_stall && bus.flush_;

`ifdef FETCH_BUF_BYPASS_EN
    assign byp_live = (count_q == '0) && bus.flush_ && !bus.in_e_;
`else
    assign byp_live = 1'b0;
`endif
    assign byp_n  = (in_n > CNT_W'(OUT_WIDTH)) ? CNT_W'(OUT_WIDTH) : in_n;
    // Bypassed instructions that decode takes this cycle are not written at all.
    assign skip_n = (byp_live && !bus.dec_stall) ? byp_n : '0;
    assign push_n = push_ok ? (in_n - skip_n) : '0;
    assign pop_n  = (!bus.dec_stall && bus.flush_)
                  ? ((count_q > CNT_W'(OUT_WIDTH)) ? CNT_W'(OUT_WIDTH) : count_q)
                  : '0;

    for (genvar i = 0; i < IN_WIDTH; i++) begin : g_wr
        assign we[i]    = push_ok && (CNT_W'(i) >= skip_n) && (CNT_W'(i) < in_n);
        assign waddr[i] = tail + PTR_W'(i) - PTR_W'(skip_n);
        assign wdata[i] = {bus.in_pc + ADDR'(i * PC_STEP), bus.in_inst[i*INST +: INST]};
    end

    fetch_buffer_mw_ram #(
        .DEPTH    (DEPTH),
        .WIDTH    (EW),
        .WR_PORTS (IN_WIDTH),
        .RD_PORTS (OUT_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

    for (genvar j = 0; j < OUT_WIDTH; j++) begin : g_out
        logic [ADDR-1:0] mem_pc, byp_pc;
        logic [INST-1:0] mem_inst, byp_inst;
        logic            slot_live, byp_slot;

        assign raddr[j]            = head + PTR_W'(j);
        assign {mem_pc, mem_inst}  = rdata[j];
        assign slot_live           = bus.flush_ && (CNT_W'(j) < count_q);
`ifdef FETCH_BUF_BYPASS_EN
        if (j < IN_WIDTH) begin : g_byp
            assign byp_slot = byp_live && (CNT_W'(j) < in_n);
            assign byp_pc   = bus.in_pc + ADDR'(j * PC_STEP);
            assign byp_inst = bus.in_inst[j*INST +: INST];
        end else begin : g_nobyp
            assign byp_slot = 1'b0;
            assign byp_pc   = '0;
            assign byp_inst = '0;
        end
`else
        assign byp_slot = 1'b0;
        assign byp_pc   = '0;
        assign byp_inst = '0;
`endif
        assign out_e_v[j]    = !(slot_live || byp_slot);
        assign out_pc_v[j]   = byp_slot ? byp_pc   : mem_pc;
        assign out_inst_v[j] = byp_slot ? byp_inst : mem_inst;
    end

    assign bus.out_e_   = out_e_v;
    assign bus.out_pc   = out_pc_v;
    assign bus.out_inst = out_inst_v;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else if (!bus.flush_) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            head    <= head + PTR_W'(pop_n);
            tail    <= tail + PTR_W'(push_n);
            count_q <= count_q + push_n - pop_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && bus.flush_) begin
            assert (int'(count_q) + int'(push_n) - int'(pop_n) >= 0 &&
                    int'(count_q) + int'(push_n) - int'(pop_n) <= DEPTH);
        end
    end
endmodule

// File: tb/tb_fetch_buffer_mw.sv
// tb/tb_fetch_buffer_mw.sv - directed-vector bench for fetch_buffer_mw
module tb_fetch_buffer_mw;
    import fetch_buffer_mw_pkg::*;

    localparam int ADDR = 32, INST = 32, DEPTH = 8, IN_WIDTH = 2, OUT_WIDTH = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    fetch_buffer_mw_if #(.ADDR(ADDR), .INST(INST), .DEPTH(DEPTH),
                         .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) bus ();

    fetch_buffer_mw #(.ADDR(ADDR), .INST(INST), .DEPTH(DEPTH),
                      .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .PC_STEP(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic e_, input logic [1:0] cnt, input logic [31:0] pc,
                         input logic ds, input logic fl);
        bus.in_e_     = e_;
        bus.in_cnt    = cnt;
        bus.in_pc     = pc;
        bus.in_inst   = {inst_of(pc + 32'd4), inst_of(pc)};
        bus.dec_stall = ds;
        bus.flush_    = fl;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [1:0] e_,
                             input logic [31:0] pc0, input logic [31:0] pc1);
        check({tag, ".e"}, bus.out_e_, e_);
        if (!e_[0]) begin
            check({tag, ".pc0"}, bus.out_pc[0 +: ADDR], pc0);
            check({tag, ".in0"}, bus.out_inst[0 +: INST], inst_of(pc0));
        end
        if (!e_[1]) begin
            check({tag, ".pc1"}, bus.out_pc[ADDR +: ADDR], pc1);
            check({tag, ".in1"}, bus.out_inst[INST +: INST], inst_of(pc1));
        end
    endtask

    initial begin
        drive(1'b1, 2'd0, 32'h0, 1'b1, 1'b1);
        check("rst.count", bus.count, 0);
        check("rst.stall", bus.in_stall, 0);
        check("rst.e", bus.out_e_, 2'b11);
        #10 reset = 1'b0;

        // First group lands one cycle later, decode stalled.
        drive(1'b0, 2'd2, 32'h1000, 1'b1, 1'b1);
        tick;
        check("t1.count", bus.count, 2);
        check_out("t1", 2'b00, 32'h1000, 32'h1004);

        drive(1'b0, 2'd0, 32'h9000, 1'b1, 1'b1);
        tick;
        check("noop.count", bus.count, 2);

        // Fill to 7 of 8: a 2-wide group no longer fits.
        drive(1'b0, 2'd2, 32'h1008, 1'b1, 1'b1); tick;
        drive(1'b0, 2'd2, 32'h1010, 1'b1, 1'b1); tick;
        drive(1'b0, 2'd1, 32'h1018, 1'b1, 1'b1); tick;
        check("fill.count", bus.count, 7);
        drive(1'b0, 2'd2, 32'h1020, 1'b1, 1'b1);
        check("fill.stall", bus.in_stall, 1);
        tick;
        check("drop.count", bus.count, 7);

        drive(1'b1, 2'd0, 32'h0, 1'b0, 1'b1);
        check_out("pop_pre", 2'b00, 32'h1000, 32'h1004);
        tick;
        check("pop.count", bus.count, 5);
        check("pop.stall", bus.in_stall, 0);
        check_out("pop", 2'b00, 32'h1008, 32'h100C);

        // Flush at count 5 with a push that must vanish.
        drive(1'b0, 2'd2, 32'h3000, 1'b1, 1'b0);
        check("flush.cyc_e", bus.out_e_, 2'b11);
        tick;
        check("flush.count", bus.count, 0);
        check("flush.stall", bus.in_stall, 0);
        check("flush.e", bus.out_e_, 2'b11);

        // Walk head/tail to 6.
        drive(1'b0, 2'd2, 32'h4000, 1'b1, 1'b1); tick;
        drive(1'b0, 2'd2, 32'h4008, 1'b1, 1'b1); tick;
        drive(1'b0, 2'd2, 32'h4010, 1'b1, 1'b1); tick;
        check("prep.count", bus.count, 6);
        drive(1'b1, 2'd0, 32'h0, 1'b0, 1'b1);
        check_out("prep0", 2'b00, 32'h4000, 32'h4004); tick;
        check_out("prep1", 2'b00, 32'h4008, 32'h400C); tick;
        check_out("prep2", 2'b00, 32'h4010, 32'h4014); tick;
        check("prep.empty", bus.count, 0);
        check("prep.e", bus.out_e_, 2'b11);

        // Groups at indices 6,7 then 0,1.
        drive(1'b0, 2'd2, 32'h5000, 1'b1, 1'b1); tick;
        drive(1'b0, 2'd2, 32'h5008, 1'b1, 1'b1); tick;
        check("wrap.count", bus.count, 4);
        check_out("wrap0", 2'b00, 32'h5000, 32'h5004);

        // Push 2 and pop 2 together at count 4.
        drive(1'b0, 2'd2, 32'h5010, 1'b0, 1'b1);
        tick;
        check("pp.count", bus.count, 4);
        check_out("wrap1", 2'b00, 32'h5008, 32'h500C);
        drive(1'b1, 2'd0, 32'h0, 1'b0, 1'b1);
        tick;
        check("pp2.count", bus.count, 2);
        check_out("wrap2", 2'b00, 32'h5010, 32'h5014);
        tick;
        check("drain.count", bus.count, 0);
        check("drain.e", bus.out_e_, 2'b11);

        // Empty queue, decode ready.
        drive(1'b0, 2'd2, 32'h2000, 1'b0, 1'b1);
`ifdef FETCH_BUF_BYPASS_EN
        check_out("byp.same", 2'b00, 32'h2000, 32'h2004);
        tick;
        check("byp.count", bus.count, 0);
        drive(1'b1, 2'd0, 32'h0, 1'b0, 1'b1);
        check("byp.after_e", bus.out_e_, 2'b11);
`else
        check("nobyp.same_e", bus.out_e_, 2'b11);
        tick;
        check("nobyp.count", bus.count, 2);
        drive(1'b1, 2'd0, 32'h0, 1'b0, 1'b1);
        check_out("nobyp.next", 2'b00, 32'h2000, 32'h2004);
`endif
        tick;
        check("end.count", bus.count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
